// File: rtl/common_cross_arbiter4_pkg.sv
// Shared definitions for the 4-way round-robin packet arbiter: state codes,
// debug view of the FSM and the round-robin pointer helper.
package common_cross_arbiter4_pkg;

   localparam int NUM_PORTS = 4;

   // FSM state codes; 2'b11 is unused and decoded as ARB_FREE
   localparam logic [1:0] ARB_FREE  = 2'b00;
   localparam logic [1:0] ARB_HOLD  = 2'b01;
   localparam logic [1:0] ARB_BURST = 2'b10;

   // Raw register view exported for checkers
   typedef struct packed {
      logic [1:0] st;
      logic [1:0] ptr;
      logic [1:0] idx;
   } arb_dbg_t;

   // Next round-robin start after serving port p (2-bit wrap, 3 -> 0)
   function automatic logic [1:0] rr_after(input logic [1:0] p);
      return p + 2'd1;
   endfunction

endpackage

// File: rtl/common_cross_arbiter4_if.sv
// Bundle of the four upstream valid/ready/last/data ports and the single
// downstream port of the arbiter.
//
// Handshake: a beat moves on a clock edge where valid and ready are both 1.
// valid never depends on ready; once valid is raised with a payload the
// source keeps valid, data and last stable until the beat is accepted.
// The arbiter drives at most one prev_o_ready bit, and only for the port it
// currently presents downstream.
interface common_cross_arbiter4_if #(
   parameter int BUFFER_WIDTH = 1
);
   logic [4*BUFFER_WIDTH-1:0] prev_i_data;
   logic [3:0]                prev_i_valid;
   logic [3:0]                prev_i_last;
   logic [3:0]                prev_o_ready;
   logic [BUFFER_WIDTH-1:0]   next_o_data;
   logic                      next_o_valid;
   logic                      next_o_last;
   logic [1:0]                next_o_src;
   logic                      next_i_ready;

   // Environment side: drives requesters and downstream ready
   modport master (
      output prev_i_data, prev_i_valid, prev_i_last, next_i_ready,
      input  prev_o_ready, next_o_data, next_o_valid, next_o_last, next_o_src
   );

   // Arbiter side
   modport slave (
      input  prev_i_data, prev_i_valid, prev_i_last, next_i_ready,
      output prev_o_ready, next_o_data, next_o_valid, next_o_last, next_o_src
   );
endinterface

// File: rtl/common_rr_pick4.sv
// Combinational round-robin picker: first set bit of i_valid scanning
// i_ptr, i_ptr+1, i_ptr+2, i_ptr+3 (mod 4).
import common_cross_arbiter4_pkg::*;

module common_rr_pick4 (
   input  logic [3:0] i_valid,
   input  logic [1:0] i_ptr,
   output logic       o_any,
   output logic [1:0] o_idx
);

   logic [1:0] w_cand;

   assign o_any = |i_valid;

   // Scan from farthest to nearest so the nearest valid port wins
   always_comb begin
      w_cand = i_ptr;
      o_idx  = i_ptr;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         w_cand = i_ptr + 2'(k);
         if (i_valid[w_cand]) o_idx = w_cand;
      end
   end

endmodule

// File: rtl/common_cross_arbiter4.sv
// 4-to-1 round-robin arbiter with packet lock. Pure pass-through: one source
// is presented downstream per cycle; a stalled offer freezes the grant (HOLD)
// and a multi-beat packet locks it until its last beat (BURST).
import common_cross_arbiter4_pkg::*;

module common_cross_arbiter4 #(
   parameter int BUFFER_WIDTH = 1,
   parameter bit LOCK_EN      = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset,
   common_cross_arbiter4_if.slave        bus,
   output arb_dbg_t                      o_dbg
);

   logic [1:0] r_st;
   logic [1:0] r_ptr;
   logic [1:0] r_idx;

   logic [1:0] w_st;
   logic [1:0] w_st_nx;
   logic [1:0] w_ptr_nx;
   logic [1:0] w_idx_nx;
   logic       w_any;
   logic [1:0] w_pick;
   logic       w_free;
   logic [1:0] w_sel;
   logic       w_offer;
   logic       w_last;
   logic [1:0] w_sel_o;

   common_rr_pick4 u_pick (
      .i_valid (bus.prev_i_valid),
      .i_ptr   (r_ptr),
      .o_any   (w_any),
      .o_idx   (w_pick)
   );

   // Illegal encoding 2'b11 behaves as FREE
   assign w_st    = (r_st == ARB_HOLD || r_st == ARB_BURST) ? r_st : ARB_FREE;
   assign w_free  = (w_st == ARB_FREE);
   assign w_sel   = w_free ? w_pick : r_idx;
   assign w_offer = w_free ? w_any : bus.prev_i_valid[r_idx];
   assign w_last  = LOCK_EN ? bus.prev_i_last[w_sel] : 1'b1;
   assign w_sel_o = reset ? w_sel : 2'd0;

   assign o_dbg = '{st: r_st, ptr: r_ptr, idx: r_idx};

   // State register: FREE/ptr 0/idx 0 on reset, abandoning any burst
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_st  <= ARB_FREE;
         r_ptr <= 2'd0;
         r_idx <= 2'd0;
      end else begin
         r_st  <= w_st_nx;
         r_ptr <= w_ptr_nx;
         r_idx <= w_idx_nx;
      end
   end

   // Next-state: grant, freeze on stall, lock on non-last beats, rotate on last
   always_comb begin
      w_st_nx  = w_st;
      w_ptr_nx = r_ptr;
      w_idx_nx = r_idx;
      case (w_st)
         ARB_HOLD: begin
            if (!w_offer) begin
               // Source withdrew its offer: release without moving ptr
               w_st_nx = ARB_FREE;
            end else if (bus.next_i_ready) begin
               if (w_last) begin
                  w_st_nx  = ARB_FREE;
                  w_ptr_nx = rr_after(r_idx);
               end else begin
                  w_st_nx = ARB_BURST;
               end
            end
         end
         ARB_BURST: begin
            if (w_offer && bus.next_i_ready && w_last) begin
               w_st_nx  = ARB_FREE;
               w_ptr_nx = rr_after(r_idx);
            end
         end
         default: begin
            if (w_offer) begin
               w_idx_nx = w_pick;
               if (bus.next_i_ready) begin
                  if (w_last) w_ptr_nx = rr_after(w_pick);
                  else        w_st_nx  = ARB_BURST;
               end else begin
                  w_st_nx = ARB_HOLD;
               end
            end
         end
      endcase
   end

   // Outputs: data mux and single ready bit, all quiet while reset is low
   always_comb begin
      bus.next_o_valid = reset & w_offer;
      bus.next_o_src   = w_sel_o;
      bus.next_o_last  = LOCK_EN ? bus.prev_i_last[w_sel_o] : 1'b1;
      bus.next_o_data  = bus.prev_i_data[BUFFER_WIDTH-1:0];
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (w_sel_o == 2'(p)) bus.next_o_data = bus.prev_i_data[p*BUFFER_WIDTH +: BUFFER_WIDTH];
      end
      bus.prev_o_ready = 4'b0000;
      if (reset && w_offer && bus.next_i_ready) bus.prev_o_ready[w_sel] = 1'b1;
   end

endmodule

// File: tb/tb_common_cross_arbiter4.sv
// Bench for common_cross_arbiter4: a locking and a non-locking instance share
// one stimulus; a grant/owner/priority model predicts every output.
import common_cross_arbiter4_pkg::*;

module tb_common_cross_arbiter4;

   localparam int BW = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [4*BW-1:0] d   = '0;
   logic [3:0]      v   = 4'h0;
   logic [3:0]      l   = 4'h0;
   logic            rdy = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;

   common_cross_arbiter4_if #(.BUFFER_WIDTH(BW)) bus_l ();
   common_cross_arbiter4_if #(.BUFFER_WIDTH(BW)) bus_n ();
   arb_dbg_t dbg_l;
   arb_dbg_t dbg_n;

   assign bus_l.prev_i_data  = d;
   assign bus_l.prev_i_valid = v;
   assign bus_l.prev_i_last  = l;
   assign bus_l.next_i_ready = rdy;
   assign bus_n.prev_i_data  = d;
   assign bus_n.prev_i_valid = v;
   assign bus_n.prev_i_last  = l;
   assign bus_n.next_i_ready = rdy;

   common_cross_arbiter4 #(.BUFFER_WIDTH(BW), .LOCK_EN(1'b1)) u_lock (
      .clk(clk), .reset(reset), .bus(bus_l.slave), .o_dbg(dbg_l)
   );
   common_cross_arbiter4 #(.BUFFER_WIDTH(BW), .LOCK_EN(1'b0)) u_nolock (
      .clk(clk), .reset(reset), .bus(bus_n.slave), .o_dbg(dbg_n)
   );

   // ---------------- scoreboard helper ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // owner: port holding the grant (-1 none); locked: owner is mid-packet;
   // prio: port that is first in round-robin order.
   int m_owner[2] = '{-1, -1};
   bit m_lock[2]  = '{1'b0, 1'b0};
   int m_prio[2]  = '{0, 0};
   int x_owner[2] = '{-1, -1};
   bit x_lock[2]  = '{1'b0, 1'b0};
   int x_prio[2]  = '{0, 0};

   // Model state advances with the DUT clock and resets asynchronously
   always @(posedge clk or negedge reset) begin
      for (int k = 0; k < 2; k++) begin
         if (!reset) begin
            m_owner[k] = -1; m_lock[k] = 1'b0; m_prio[k] = 0;
         end else begin
            m_owner[k] = x_owner[k]; m_lock[k] = x_lock[k]; m_prio[k] = x_prio[k];
         end
      end
   end

   // Compare every output of both instances on the falling edge
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int sel;
         bit lk;
         logic ev, el;
         logic [3:0] er;
         logic [BW-1:0] ed;
         logic a_v, a_l;
         logic [3:0] a_r;
         logic [1:0] a_s;
         logic [BW-1:0] a_d;
         arb_dbg_t a_dbg;
         int est;
         lk  = (k == 0);
         sel = -1;
         if (m_owner[k] >= 0) sel = m_owner[k];
         else begin
            for (int j = 0; j < 4; j++)
               if (sel < 0 && v[(m_prio[k] + j) % 4]) sel = (m_prio[k] + j) % 4;
         end
         ev = reset && (sel >= 0) && v[sel];
         er = (ev && rdy) ? 4'(1 << sel) : 4'b0000;
         el = (sel < 0) ? 1'b1 : (lk ? l[sel] : 1'b1);
         ed = reset ? d[sel*BW +: BW] : d[BW-1:0];
         est = (m_owner[k] < 0) ? 0 : (m_lock[k] ? 2 : 1);

         a_v   = (k == 0) ? bus_l.next_o_valid : bus_n.next_o_valid;
         a_r   = (k == 0) ? bus_l.prev_o_ready : bus_n.prev_o_ready;
         a_s   = (k == 0) ? bus_l.next_o_src   : bus_n.next_o_src;
         a_d   = (k == 0) ? bus_l.next_o_data  : bus_n.next_o_data;
         a_l   = (k == 0) ? bus_l.next_o_last  : bus_n.next_o_last;
         a_dbg = (k == 0) ? dbg_l : dbg_n;

         chk(lk ? "lock_valid" : "nolock_valid", 32'(a_v), 32'(ev));
         chk(lk ? "lock_ready" : "nolock_ready", 32'(a_r), 32'(er));
         chk(lk ? "lock_ptr" : "nolock_ptr", 32'(a_dbg.ptr), 32'(reset ? m_prio[k] : 0));
         chk(lk ? "lock_state" : "nolock_state", 32'(a_dbg.st), 32'(reset ? est : 0));
         if (!reset || sel >= 0) begin
            chk(lk ? "lock_src" : "nolock_src", 32'(a_s), reset ? 32'(sel) : 32'd0);
            chk(lk ? "lock_data" : "nolock_data", 32'(a_d), 32'(ed));
         end
         if (ev) chk(lk ? "lock_last" : "nolock_last", 32'(a_l), 32'(el));

         // Next state from the rules
         x_owner[k] = m_owner[k]; x_lock[k] = m_lock[k]; x_prio[k] = m_prio[k];
         if (!reset) begin
            x_owner[k] = -1; x_lock[k] = 1'b0; x_prio[k] = 0;
         end else if (m_owner[k] < 0) begin
            if (sel >= 0) begin
               if (rdy) begin
                  if (el) x_prio[k] = (sel + 1) % 4;
                  else begin x_owner[k] = sel; x_lock[k] = 1'b1; end
               end else begin
                  x_owner[k] = sel; x_lock[k] = 1'b0;
               end
            end
         end else if (!m_lock[k]) begin
            if (!v[sel]) x_owner[k] = -1;
            else if (rdy) begin
               if (el) begin x_owner[k] = -1; x_prio[k] = (sel + 1) % 4; end
               else x_lock[k] = 1'b1;
            end
         end else if (v[sel] && rdy && el) begin
            x_owner[k] = -1; x_lock[k] = 1'b0; x_prio[k] = (sel + 1) % 4;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [3:0] vv, input logic [3:0] ll, input logic rr);
      @(posedge clk); #1;
      v = vv; l = ll; rdy = rr; d = $urandom;
      #2;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b0; v = 4'h0;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // 1: reset with all ports requesting
      drive(4'hF, 4'hF, 1'b1);
      chk("rst_valid", 32'(bus_l.next_o_valid), 32'd0);
      chk("rst_ready", 32'(bus_l.prev_o_ready), 32'd0);
      chk("rst_src", 32'(bus_l.next_o_src), 32'd0);
      chk("rst_data", 32'(bus_l.next_o_data), 32'(d[7:0]));
      @(posedge clk); #1;
      reset = 1'b1;
      #2;
      chk("rel_src", 32'(bus_l.next_o_src), 32'd0);
      chk("rel_valid", 32'(bus_l.next_o_valid), 32'd1);

      // 2: rotation with single-beat traffic
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(4'hF, 4'hF, 1'b1);
         chk("rot_src", 32'(bus_l.next_o_src), 32'(i % 4));
         chk("rot_ready", 32'(bus_l.prev_o_ready), 32'(1 << (i % 4)));
      end

      // 3: hold freezes the grant
      do_reset();
      drive(4'b0100, 4'hF, 1'b0);
      chk("hold_src0", 32'(bus_l.next_o_src), 32'd2);
      chk("hold_ready0", 32'(bus_l.prev_o_ready), 32'd0);
      drive(4'b0101, 4'hF, 1'b0);
      chk("hold_src1", 32'(bus_l.next_o_src), 32'd2);
      drive(4'b0101, 4'hF, 1'b1);
      chk("hold_acc", 32'(bus_l.prev_o_ready), 32'b0100);
      drive(4'b0101, 4'hF, 1'b1);
      chk("hold_ptr", 32'(dbg_l.ptr), 32'd3);
      chk("hold_next", 32'(bus_l.next_o_src), 32'd0);

      // 4: burst on port 1 with a bubble, port 3 waiting
      do_reset();
      drive(4'b1010, 4'b0000, 1'b1);
      chk("burst_b0", 32'(bus_l.prev_o_ready), 32'b0010);
      drive(4'b1010, 4'b0000, 1'b1);
      chk("burst_b1", 32'(bus_l.prev_o_ready), 32'b0010);
      drive(4'b1000, 4'b0000, 1'b1);
      chk("burst_bub_v", 32'(bus_l.next_o_valid), 32'd0);
      chk("burst_bub_r", 32'(bus_l.prev_o_ready), 32'd0);
      drive(4'b1010, 4'b0010, 1'b1);
      chk("burst_b2", 32'(bus_l.prev_o_ready), 32'b0010);
      chk("burst_last", 32'(bus_l.next_o_last), 32'd1);
      drive(4'b1000, 4'b0000, 1'b1);
      chk("burst_after", 32'(bus_l.next_o_src), 32'd3);

      // 5: no lock when LOCK_EN=0; the locking instance stays on port 0
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(4'b0011, 4'b0000, 1'b1);
         chk("nolock_alt", 32'(bus_n.next_o_src), 32'(i % 2));
         chk("nolock_lastf", 32'(bus_n.next_o_last), 32'd1);
         chk("lock_stay", 32'(bus_l.next_o_src), 32'd0);
      end

      // 6: reset in the middle of a burst
      do_reset();
      drive(4'b0100, 4'b0000, 1'b1);
      drive(4'b0100, 4'b0000, 1'b1);
      chk("mid_state", 32'(dbg_l.st), 32'(ARB_BURST));
      @(posedge clk); #1;
      reset = 1'b0;
      #2;
      chk("mid_rst_v", 32'(bus_l.next_o_valid), 32'd0);
      chk("mid_rst_r", 32'(bus_l.prev_o_ready), 32'd0);
      chk("mid_rst_dbg", 32'(dbg_l), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1; v = 4'hF; l = 4'hF; rdy = 1'b0;
      #2;
      chk("mid_rel_src", 32'(bus_l.next_o_src), 32'd0);
      chk("mid_rel_st", 32'(dbg_l.st), 32'(ARB_FREE));

      // Random traffic against the model
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         else drive(4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15) | $urandom_range(0, 15)),
                    1'($urandom_range(0, 3) != 0));
      end

      @(posedge clk); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
